// File: rtl/health_bar.sv
// Heart-row health overlay: APB-captured health applied on frame pulses,
// lost hearts blink before vanishing; registered one-bit pixel output.
module health_bar #(
   parameter int MAX_HEARTS   = 5,
   parameter int SCALE        = 6,
   parameter int GAP          = 6,
   parameter int BLINK_FRAMES = 8,
   localparam int HW          = $clog2(MAX_HEARTS + 1)
) (
   input  logic          clk,
   input  logic          res,
   input  logic          write_en0,
   input  logic          right_addr,
   input  logic [31:0]   pwdata,
   input  logic          animate,
   input  logic [9:0]    x,
   input  logic [8:0]    y,
   input  logic [9:0]    x0,
   input  logic [8:0]    y0,
   output logic          h,
   output logic [HW-1:0] health,
   output logic          blinking,
   output logic          dead
);

   localparam int WID   = 9 * SCALE;
   localparam int HGT   = 7 * SCALE;
   localparam int PITCH = WID + GAP;

   localparam logic [HW-1:0] MAXH = HW'(MAX_HEARTS);
   localparam logic [7:0]    BF   = 8'(BLINK_FRAMES);

   typedef enum logic {
      IDLE,
      BLINK
   } state_t;

   state_t          state;
   logic [HW-1:0]   req;
   logic [HW-1:0]   shown;
   logic [HW-1:0]   lost_hi;
   logic [7:0]      cnt;
   logic [HW-1:0]   wr_val;
   logic            unused_pwdata;

   assign unused_pwdata = ^pwdata[31:HW];
   assign wr_val = (pwdata[HW-1:0] > MAXH) ? MAXH : pwdata[HW-1:0];

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         req <= MAXH;
      end else if (write_en0 && right_addr) begin
         req <= wr_val;
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state   <= IDLE;
         shown   <= MAXH;
         lost_hi <= MAXH;
         cnt     <= '0;
      end else if (animate) begin
         unique case (state)
            IDLE: begin
               if (req < shown) begin
                  lost_hi <= shown;
                  shown   <= req;
                  cnt     <= BF;
                  state   <= BLINK;
               end else if (req > shown) begin
                  shown <= req;
               end
            end
            BLINK: begin
               if (req >= lost_hi) begin
                  shown <= req;
                  state <= IDLE;
               end else if (req < shown) begin
                  shown <= req;
                  cnt   <= BF;
               end else begin
                  // partial heal keeps counting; still-lost hearts keep blinking
                  shown <= req;
                  cnt   <= cnt - 8'd1;
                  if (cnt == 8'd1) begin
                     state   <= IDLE;
                     lost_hi <= req;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign health   = shown;
   assign blinking = (state == BLINK);
   assign dead     = (state == IDLE) && (shown == '0);

   function automatic logic cell_lit(
      input logic [10:0] dx,
      input logic [9:0]  dy
   );
      logic [3:0] col;
      logic [2:0] row;
      logic [8:0] mask;
      col = '0;
      row = '0;
      for (int c = 1; c < 9; c++) begin
         if (dx >= 11'(c * SCALE)) col = col + 4'd1;
      end
      for (int r = 1; r < 7; r++) begin
         if (dy >= 10'(r * SCALE)) row = row + 3'd1;
      end
      case (row)
         3'd0:    mask = 9'h010;
         3'd1:    mask = 9'h038;
         3'd2:    mask = 9'h07c;
         3'd3:    mask = 9'h0fe;
         3'd4:    mask = 9'h1ff;
         3'd5:    mask = 9'h1ef;
         3'd6:    mask = 9'h0c6;
         default: mask = 9'h000;
      endcase
      return mask[col];
   endfunction

   logic [MAX_HEARTS-1:0] vis;
   logic [MAX_HEARTS-1:0] on;
   logic [9:0]            dy;
   logic                  y_in;

   always_comb begin
      vis = '0;
      for (int k = 0; k < MAX_HEARTS; k++) begin
         if (HW'(k) < shown) begin
            vis[k] = 1'b1;
         end else if (state == BLINK && HW'(k) < lost_hi) begin
            vis[k] = cnt[0];
         end
      end
   end

   assign dy   = {1'b0, y} - {1'b0, y0};
   assign y_in = ({1'b0, y} >= {1'b0, y0}) && (dy < 10'(HGT));

   for (genvar k = 0; k < MAX_HEARTS; k++) begin : g_heart
      logic [10:0] ox;
      logic [10:0] dx;
      // origins past the screen edge simply never match; no wrap
      assign ox = {1'b0, x0} + 11'(k * PITCH);
      assign dx = {1'b0, x} - ox;
      assign on[k] = vis[k] & y_in
                   & ({1'b0, x} >= ox)
                   & (dx < 11'(WID))
                   & cell_lit(dx, dy);
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         h <= 1'b0;
      end else begin
         h <= |on;
      end
   end

endmodule
